cic_decim_ctrl: RTL

Sequencer for the 3-stage CIC decimator, running in the in_clk sample domain. It generates the single-cycle decimation strobe (the CIC out_clk input) at a programmable ratio. It drives the CIC reset so the filter is flushed on enable and on every ratio change, and discards the start-up transient outputs. It buffers valid CIC outputs in a small FIFO with a valid/ready interface toward the downstream consumer.

---
 rtl/cic_pkg.sv | 35 +++
 rtl/cic_decim_ctrl_if.sv | 33 +++
 rtl/cic_out_fifo.sv | 67 ++++++
 rtl/cic_decim_ctrl.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared constants, types and helpers for the CIC decimator sequencer.
package cic_pkg;

    localparam int unsigned NUM_STAGES     = 3;
    localparam int unsigned STG_GSZ        = 5;
    localparam int unsigned ISZ            = 16;
    localparam int unsigned OSZ            = ISZ + NUM_STAGES * STG_GSZ;

    localparam int unsigned RATIO_W        = 6;
    localparam int unsigned RATIO_MIN      = 2;
    localparam int unsigned RATIO_MAX      = 32;
    localparam int unsigned DEFAULT_RATIO  = 32;

    localparam int unsigned FLUSH_CYCLES   = 2;
    localparam int unsigned SETTLE_OUTPUTS = 3;
    localparam int unsigned FIFO_DEPTH     = 4;

    localparam int unsigned FLUSH_CNT_W    = $clog2(FLUSH_CYCLES + 1);
    localparam int unsigned SETTLE_CNT_W   = $clog2(SETTLE_OUTPUTS + 1);

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        SETTLE,
        RUN
    } ctrl_state_t;

    typedef logic [OSZ-1:0]     sample_t;
    typedef logic [RATIO_W-1:0] ratio_t;

    function automatic logic ratio_legal(input ratio_t r);
        return (r >= RATIO_W'(RATIO_MIN)) && (r <= RATIO_W'(RATIO_MAX));
    endfunction

endpackage

// File: rtl/cic_decim_ctrl_if.sv
// Control, CIC-side and stream-side signals of the decimator sequencer.
interface cic_decim_ctrl_if;
    import cic_pkg::*;

    logic    enable;
    logic    ratio_wr;
    ratio_t  ratio_in;
    ratio_t  ratio_cur;
    logic    ratio_err;
    logic    cic_reset;
    logic    cic_dec_stb;
    sample_t cic_out;
    logic    cic_out_valid;
    sample_t m_data;
    logic    m_valid;
    logic    m_ready;
    logic    running;
    logic    overflow;
    logic    overflow_clr;

    // master: the surroundings (control plane, CIC, consumer)
    modport master (
        output enable, ratio_wr, ratio_in, cic_out, cic_out_valid, m_ready, overflow_clr,
        input  ratio_cur, ratio_err, cic_reset, cic_dec_stb, m_data, m_valid, running, overflow
    );

    // slave: the sequencer itself
    modport slave (
        input  enable, ratio_wr, ratio_in, cic_out, cic_out_valid, m_ready, overflow_clr,
        output ratio_cur, ratio_err, cic_reset, cic_dec_stb, m_data, m_valid, running, overflow
    );

endinterface

// File: rtl/cic_out_fifo.sv
// Show-ahead synchronous FIFO buffering CIC output samples.
module cic_out_fifo
    import cic_pkg::*;
#(
    parameter int unsigned WIDTH = OSZ,
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_en;
    logic             rd_en;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    // a full FIFO still accepts a push when the same cycle pops
    assign rd_en = pop_i && !empty_o;
    assign wr_en = push_i && (!full_o || rd_en);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(wr_en) - CW'(rd_en);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/cic_decim_ctrl.sv
// CIC decimator sequencer: decimation strobe, flush/settle control and output buffering.
module cic_decim_ctrl
    import cic_pkg::*;
(
    input  logic             in_clk,
    input  logic             reset,
    cic_decim_ctrl_if.slave  bus
);

    ctrl_state_t             state_q, state_d;
    ratio_t                  ratio_q, ratio_d;
    ratio_t                  phase_q, phase_d;
    logic [FLUSH_CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [SETTLE_CNT_W-1:0] discard_q, discard_d;
    logic                    ratio_err_q, ratio_err_d;
    logic                    overflow_q, overflow_d;

    logic    legal_wr;
    logic    active;
    logic    phase_last;
    logic    fifo_push;
    logic    fifo_pop;
    logic    fifo_full;
    logic    fifo_empty;
    logic    drop;
    sample_t fifo_data;

    assign legal_wr   = bus.ratio_wr && ratio_legal(bus.ratio_in);
    assign active     = (state_q == SETTLE) || (state_q == RUN);
    assign phase_last = (phase_q == ratio_q - RATIO_W'(1));
    assign fifo_push  = (state_q == RUN) && bus.cic_out_valid;
    assign fifo_pop   = !fifo_empty && bus.m_ready;
    assign drop       = fifo_push && fifo_full && !fifo_pop;

    // next-state, ratio, counters and sticky flags
    always_comb begin
        state_d     = state_q;
        ratio_d     = ratio_q;
        phase_d     = '0;
        flush_cnt_d = flush_cnt_q;
        discard_d   = discard_q;
        ratio_err_d = 1'b0;
        overflow_d  = overflow_q;

        if (legal_wr) begin
            ratio_d = bus.ratio_in;
        end
        if (bus.ratio_wr && !legal_wr) begin
            ratio_err_d = 1'b1;
        end

        if (drop) begin
            overflow_d = 1'b1;
        end else if (bus.overflow_clr) begin
            overflow_d = 1'b0;
        end

        if (active) begin
            phase_d = phase_last ? '0 : phase_q + RATIO_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    state_d     = FLUSH;
                    flush_cnt_d = '0;
                end
            end
            FLUSH: begin
                discard_d = '0;
                if (flush_cnt_q == FLUSH_CNT_W'(FLUSH_CYCLES - 1)) begin
                    state_d = SETTLE;
                end else begin
                    flush_cnt_d = flush_cnt_q + FLUSH_CNT_W'(1);
                end
            end
            SETTLE: begin
                if (bus.cic_out_valid) begin
                    discard_d = discard_q + SETTLE_CNT_W'(1);
                    if (discard_q == SETTLE_CNT_W'(SETTLE_OUTPUTS - 1)) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // a ratio change restarts the flush; dropping enable beats everything
        if (state_q != IDLE && legal_wr) begin
            state_d     = FLUSH;
            flush_cnt_d = '0;
        end
        if (state_q != IDLE && !bus.enable) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge in_clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ratio_q     <= RATIO_W'(DEFAULT_RATIO);
            phase_q     <= '0;
            flush_cnt_q <= '0;
            discard_q   <= '0;
            ratio_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ratio_q     <= ratio_d;
            phase_q     <= phase_d;
            flush_cnt_q <= flush_cnt_d;
            discard_q   <= discard_d;
            ratio_err_q <= ratio_err_d;
            overflow_q  <= overflow_d;
        end
    end

    cic_out_fifo #(
        .WIDTH (OSZ),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (in_clk),
        .rst_i   (reset),
        .push_i  (fifo_push),
        .data_i  (bus.cic_out),
        .pop_i   (fifo_pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // CIC-facing controls are plain decodes of the state and phase registers
    assign bus.cic_reset   = (state_q == IDLE) || (state_q == FLUSH);
    assign bus.cic_dec_stb = active && phase_last;
    assign bus.running     = (state_q == RUN);
    assign bus.ratio_cur   = ratio_q;
    assign bus.ratio_err   = ratio_err_q;
    assign bus.overflow    = overflow_q;
    assign bus.m_valid     = !fifo_empty;
    assign bus.m_data      = fifo_data;

endmodule
